// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display feeder.
// The leading-zero blanking helper is only referenced when HEXDISP_LZB_EN is defined.
package hex_disp_pkg;

    typedef enum logic {
        PAGE_LO = 1'b0,
        PAGE_HI = 1'b1
    } page_t;

    localparam int NUM_DIGITS = 6;
    localparam int HI_DIGITS  = 2;
    localparam int NIB_W      = 4 * NUM_DIGITS;

    // Digit k (k>0) is lit when it or any more-significant digit is nonzero.
    // Digit 0 always stays lit so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lzb_enables(input logic [NIB_W-1:0] nib);
        logic [NUM_DIGITS-1:0] en;
        logic                  seen;
        en   = '0;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen  = seen | (nib[4*k +: 4] != 4'h0);
            en[k] = seen;
        end
        en[0] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: two-flop synchronizer plus rising-edge detector.
// btn_edge is a one-cycle pulse; a held button produces a single pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_edge
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronize the raw level and remember the previous synchronized level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Hex display feeder: captures a 32-bit word and pages it onto six nibble
// digits (low 24 bits, or high 8 bits on two digits). Paging by button or
// dwell timer. Optional macro HEXDISP_LZB_EN enables leading-zero blanking.
//
//   state   | meaning
//   --------+-------------------------------------------
//   PAGE_LO | showing val[23:0] on digits 5..0
//   PAGE_HI | showing val[31:24] on digits 1..0
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [31:0]           data_in,
    input  logic                  freeze,
    input  logic                  page_btn,
    input  logic                  auto_en,
    output logic [NIB_W-1:0]      nibbles,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  page,
    output logic                  updated
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

`ifdef HEXDISP_LZB_EN
    localparam logic [NUM_DIGITS-1:0] EN_RST = NUM_DIGITS'(1);
`else
    localparam logic [NUM_DIGITS-1:0] EN_RST = '1;
    localparam logic [NUM_DIGITS-1:0] EN_HI  = NUM_DIGITS'((1 << HI_DIGITS) - 1);
`endif

    logic                  btn_edge;
    logic                  dwell_expire;
    logic                  toggle;
    logic                  capture;

    page_t                 page_q, page_d;
    logic [31:0]           val_q, val_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NIB_W-1:0]      nib_q, nib_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  upd_q, upd_d;

    btn_sync_edge u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (page_btn),
        .btn_edge (btn_edge)
    );

    assign capture      = load & ~freeze;
    assign dwell_expire = auto_en & (cnt_q == CNT_LAST);
    // A button edge and a dwell expiry in the same cycle merge into one toggle.
    assign toggle       = btn_edge | dwell_expire;

    // Page FSM next-state.
    always_comb begin
        page_d = page_q;
        unique case (page_q)
            PAGE_LO: if (toggle) page_d = PAGE_HI;
            PAGE_HI: if (toggle) page_d = PAGE_LO;
            default: page_d = PAGE_LO;
        endcase
    end

    // Value capture, dwell counter and display mapping; outputs are built
    // from next-state values so they settle one cycle after the cause.
    always_comb begin
        val_d = val_q;
        upd_d = 1'b0;
        cnt_d = cnt_q;
        nib_d = '0;
        en_d  = EN_RST;

        if (capture) begin
            val_d = data_in;
            upd_d = (data_in != val_q);
        end

        if (!auto_en || btn_edge || dwell_expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (page_d == PAGE_HI) begin
            nib_d[4*HI_DIGITS-1:0] = val_d[31 -: 4*HI_DIGITS];
        end else begin
            nib_d = val_d[NIB_W-1:0];
        end

`ifdef HEXDISP_LZB_EN
        en_d = lzb_enables(nib_d);
`else
        en_d = (page_d == PAGE_HI) ? EN_HI : '1;
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            page_q <= PAGE_LO;
            val_q  <= '0;
            cnt_q  <= '0;
            nib_q  <= '0;
            en_q   <= EN_RST;
            upd_q  <= 1'b0;
        end else begin
            page_q <= page_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            nib_q  <= nib_d;
            en_q   <= en_d;
            upd_q  <= upd_d;
        end
    end

    assign nibbles  = nib_q;
    assign digit_en = en_q;
    assign page     = (page_q == PAGE_HI);
    assign updated  = upd_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl with a short dwell period.
// Expected enables follow HEXDISP_LZB_EN when the macro is defined.
module tb_hex_display_ctrl;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] data_in;
    logic        freeze;
    logic        page_btn;
    logic        auto_en;
    logic [23:0] nibbles;
    logic [5:0]  digit_en;
    logic        page;
    logic        updated;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_val  = '0;
    bit          m_page = 1'b0;
    int          m_cnt  = 0;
    bit [2:0]    m_raw  = '0;   // [0] newest raw sample, [2] oldest
    logic [23:0] m_nib  = '0;
    logic [5:0]  m_en   = 6'h3F;
    bit          m_upd  = 1'b0;

    hex_display_ctrl #(.DWELL_CYCLES(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data_in  (data_in),
        .freeze   (freeze),
        .page_btn (page_btn),
        .auto_en  (auto_en),
        .nibbles  (nibbles),
        .digit_en (digit_en),
        .page     (page),
        .updated  (updated)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_en(input logic [23:0] nib, input bit pg);
        logic [5:0] en;
`ifdef HEXDISP_LZB_EN
        int top;
        top = 0;
        for (int k = 0; k < 6; k++)
            if (((nib >> (4 * k)) & 24'hF) != 0) top = k;
        for (int k = 0; k < 6; k++)
            en[k] = (k <= top);
        if (pg) en = en;
`else
        if (nib == 24'hFFFFFF) en = 6'h3F;
        en = pg ? 6'b000011 : 6'b111111;
`endif
        return en;
    endfunction

    task automatic model_edge();
        bit be;
        bit ex;
        if (reset) begin
            m_val  = '0;
            m_page = 1'b0;
            m_cnt  = 0;
            m_raw  = '0;
            m_upd  = 1'b0;
        end else begin
            be = m_raw[1] && !m_raw[2];
            ex = auto_en && (m_cnt == DW - 1);
            if (!auto_en || be || ex) m_cnt = 0;
            else                      m_cnt = m_cnt + 1;
            if (be || ex) m_page = !m_page;
            m_upd = load && !freeze && (data_in != m_val);
            if (load && !freeze) m_val = data_in;
            m_raw = {m_raw[1:0], page_btn};
        end
        m_nib = m_page ? {16'h0, m_val[31:24]} : m_val[23:0];
        m_en  = exp_en(m_nib, m_page);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".page"},     {31'b0, page},     {31'b0, m_page});
        chk({tag, ".nibbles"},  {8'b0, nibbles},   {8'b0, m_nib});
        chk({tag, ".digit_en"}, {26'b0, digit_en}, {26'b0, m_en});
        chk({tag, ".updated"},  {31'b0, updated},  {31'b0, m_upd});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int n;
        bit seen;

        reset    = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        freeze   = 1'b0;
        page_btn = 1'b0;
        auto_en  = 1'b0;

        step("rst");
        step("rst");
        chk("rst.nibbles",  {8'b0, nibbles},   32'h0);
        chk("rst.page",     {31'b0, page},     32'h0);
        chk("rst.updated",  {31'b0, updated},  32'h0);
`ifdef HEXDISP_LZB_EN
        chk("rst.digit_en", {26'b0, digit_en}, 32'h01);
`else
        chk("rst.digit_en", {26'b0, digit_en}, 32'h3F);
`endif
        reset = 1'b0;
        step("idle");

        // First load
        load = 1'b1; data_in = 32'h12345678;
        step("load1");
        chk("load1.nibbles", {8'b0, nibbles},  32'h345678);
        chk("load1.updated", {31'b0, updated}, 32'h1);
        load = 1'b0;
        step("load1.after");
        chk("load1.pulse_end", {31'b0, updated}, 32'h0);

        // Button held 5 cycles: toggle on 3rd edge, only once
        page_btn = 1'b1;
        step("btn.e1");
        step("btn.e2");
        chk("btn.not_yet", {31'b0, page}, 32'h0);
        step("btn.e3");
        chk("btn.page",    {31'b0, page},    32'h1);
        chk("btn.nibbles", {8'b0, nibbles},  32'h000012);
        step("btn.e4");
        step("btn.e5");
        page_btn = 1'b0;
        for (int i = 0; i < 4; i++) step("btn.rel");
        chk("btn.single", {31'b0, page}, 32'h1);

        // Frozen load, then equal reload
        freeze = 1'b1; load = 1'b1; data_in = 32'hDEADBEEF;
        step("frz");
        chk("frz.updated", {31'b0, updated}, 32'h0);
        chk("frz.nibbles", {8'b0, nibbles},  32'h000012);
        freeze = 1'b0; data_in = 32'h12345678;
        step("reload");
        chk("reload.updated", {31'b0, updated}, 32'h0);
        load = 1'b0;
        step("reload.after");

        // Back to PAGE_LO by button
        page_btn = 1'b1;
        for (int i = 0; i < 3; i++) step("btn2");
        chk("btn2.page", {31'b0, page}, 32'h0);
        page_btn = 1'b0;
        for (int i = 0; i < 3; i++) step("btn2.rel");

        // Auto rotation: toggles at edges 4, 8, 12
        auto_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step("auto");
            if (i == 4 || i == 12) chk("auto.hi", {31'b0, page}, 32'h1);
            if (i == 8)            chk("auto.lo", {31'b0, page}, 32'h0);
        end

        // Button edge coinciding with expiry at edge 16
        step("coin.e13");
        page_btn = 1'b1;
        step("coin.e14");
        step("coin.e15");
        step("coin.e16");
        chk("coin.single", {31'b0, page}, 32'h0);
        for (int i = 0; i < 3; i++) step("coin.hold");
        chk("coin.restart_wait", {31'b0, page}, 32'h0);
        step("coin.e20");
        chk("coin.restart", {31'b0, page}, 32'h1);
        page_btn = 1'b0;

        // Reset mid-dwell on PAGE_HI
        step("mid");
        step("mid");
        reset = 1'b1;
        step("mid.rst");
        chk("mid.page",    {31'b0, page},   32'h0);
        chk("mid.nibbles", {8'b0, nibbles}, 32'h0);
        reset = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            step("mid.wait");
            n++;
            if (page) seen = 1'b1;
        end
        chk("mid.first_toggle", n, DW);

        auto_en = 1'b0;
        step("auto.off");

        // Randomized phase against the model
        for (int i = 0; i < 500; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            load   = ($urandom_range(0, 2) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       data_in = m_val;
                1:       data_in = 32'($urandom_range(0, 4095));
                default: data_in = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0)  page_btn = ~page_btn;
            if ($urandom_range(0, 30) == 0) auto_en  = ~auto_en;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
